// File: rtl/instr_wb_master_pkg.sv
// Shared types and defaults for the instrumentation Wishbone blocks.
package instr_wb_master_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;
    localparam int unsigned TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/instr_wb_master.sv
// Single-outstanding Wishbone (pipelined) master for instrumentation requests,
// with an ack timeout that aborts the cycle and flags the response.
module instr_wb_master
    import instr_wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    output logic                wb_we_o,
    output logic [WB_SEL_W-1:0] wb_sel_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    output logic                wb_cyc_o,
    input  logic                wb_stall_i,
    input  logic                req_valid_i,
    input  logic                req_we_i,
    input  logic [WB_ADR_W-1:0] req_adr_i,
    input  logic [WB_DAT_W-1:0] req_dat_i,
    input  logic [WB_SEL_W-1:0] req_sel_i,
    output logic                busy_o,
    output logic                resp_valid_o,
    output logic [WB_DAT_W-1:0] resp_dat_o,
    output logic                resp_timeout_o
);

    // Counter value seen on the last WAIT_ACK cycle before the timeout fires.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_t             state_q, state_d;
    wb_req_t               req_q, req_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  busy_q, busy_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic [WB_DAT_W-1:0]   resp_dat_q, resp_dat_d;
    logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    // Next-state and next-output logic; every output is the image of a register.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        cyc_d          = cyc_q;
        stb_d          = stb_q;
        busy_d         = busy_q;
        resp_valid_d   = 1'b0;
        resp_timeout_d = resp_timeout_q;
        resp_dat_d     = resp_dat_q;
        tmo_cnt_d      = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d.we  = req_we_i;
                    req_d.adr = req_adr_i;
                    req_d.dat = req_dat_i;
                    req_d.sel = req_sel_i;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (!wb_stall_i) begin
                    stb_d     = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (wb_ack_i) begin
                    if (!req_q.we) begin
                        resp_dat_d = wb_dat_i;
                    end
                    cyc_d          = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b0;
                    state_d        = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                    if (tmo_cnt_q == TMO_LAST) begin
                        cyc_d          = 1'b0;
                        resp_valid_d   = 1'b1;
                        resp_timeout_d = 1'b1;
                        state_d        = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            cyc_q          <= 1'b0;
            stb_q          <= 1'b0;
            busy_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_dat_q     <= '0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            cyc_q          <= cyc_d;
            stb_q          <= stb_d;
            busy_q         <= busy_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
            resp_dat_q     <= resp_dat_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    assign wb_adr_o       = req_q.adr;
    assign wb_dat_o       = req_q.dat;
    assign wb_we_o        = req_q.we;
    assign wb_sel_o       = req_q.sel;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb_q;
    assign busy_o         = busy_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_timeout_o = resp_timeout_q;
    assign resp_dat_o     = resp_dat_q;

endmodule
